// File: rtl/mult_div_unit.sv
// Iterative radix-2 MIPS multiply/divide unit (MULT, MULTU, DIV, DIVU).
// Works on operand magnitudes and applies the sign correction when entering DONE.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             Clock,
   input  logic             ResetN,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [CW-1:0]    r_cnt;
   logic             r_op_div;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_b_zero;
   logic [WIDTH-1:0] r_mb;
   logic [WIDTH-1:0] r_acc_hi;
   logic [WIDTH-1:0] r_acc_lo;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   logic w_capture;
   logic w_iterate;
   logic w_finish;

   // Operand capture: signed ops keep magnitudes plus the result sign flags
   logic             w_signed;
   logic             w_sa;
   logic             w_sb;
   logic [WIDTH-1:0] w_mag_a;
   logic [WIDTH-1:0] w_mag_b;

   assign w_signed = ~Op[0];
   assign w_sa     = w_signed & A[WIDTH-1];
   assign w_sb     = w_signed & B[WIDTH-1];
   assign w_mag_a  = w_sa ? -A : A;
   assign w_mag_b  = w_sb ? -B : B;

   // Shift-add multiply step: {acc_hi, acc_lo} shifts right, acc_lo[0] is the multiplier bit
   logic [WIDTH:0] w_madd;
   assign w_madd = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mb} : {(WIDTH+1){1'b0}});

   // Restoring divide step: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in
   logic [WIDTH:0] w_dshift;
   logic [WIDTH:0] w_dsub;
   logic           w_dge;
   assign w_dshift = {r_acc_hi, r_acc_lo[WIDTH-1]};
   assign w_dsub   = w_dshift - {1'b0, r_mb};
   assign w_dge    = (w_dshift >= {1'b0, r_mb});

   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_quo_fix;
   logic [WIDTH-1:0]   w_rem_fix;
   assign w_prod     = {r_acc_hi, r_acc_lo};
   assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
   // A zero divisor yields all-ones quotient; remainder magnitude is |A|, so sign fix restores A
   assign w_quo_fix  = r_b_zero ? {WIDTH{1'b1}} : (r_neg_q ? -r_acc_lo : r_acc_lo);
   assign w_rem_fix  = r_neg_r ? -r_acc_hi : r_acc_hi;

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      w_iterate    = 1'b0;
      w_finish     = 1'b0;
      Busy         = 1'b0;
      Done         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (Start) begin
               w_capture    = 1'b1;
               w_state_next = S_RUN;
            end
         end
         S_RUN: begin
            Busy = 1'b1;
            if (r_cnt == CW'(WIDTH)) begin
               w_finish     = 1'b1;
               w_state_next = S_DONE;
            end else begin
               w_iterate = 1'b1;
            end
         end
         S_DONE: begin
            Busy         = 1'b1;
            Done         = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         r_cnt    <= '0;
         r_op_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_b_zero <= 1'b0;
         r_mb     <= '0;
         r_acc_hi <= '0;
         r_acc_lo <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         if (w_capture) begin
            r_cnt    <= '0;
            r_op_div <= Op[1];
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_b_zero <= (B == '0);
            r_mb     <= w_mag_b;
            r_acc_hi <= '0;
            r_acc_lo <= w_mag_a;
         end
         if (w_iterate) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_op_div) begin
               r_acc_hi <= w_dge ? w_dsub[WIDTH-1:0] : w_dshift[WIDTH-1:0];
               r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_dge};
            end else begin
               r_acc_hi <= w_madd[WIDTH:1];
               r_acc_lo <= {w_madd[0], r_acc_lo[WIDTH-1:1]};
            end
         end
         if (w_finish) begin
            if (r_op_div) begin
               r_hi <= w_rem_fix;
               r_lo <= w_quo_fix;
            end else begin
               r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
               r_lo <= w_prod_fix[WIDTH-1:0];
            end
         end
      end
   end

   assign Hi = r_hi;
   assign Lo = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed vectors push expected Hi/Lo/latency,
// a monitor pops and compares on every Done pulse.
module tb_mult_div_unit;

   localparam int W = 32;

   logic         Clock;
   logic         ResetN;
   logic         Start;
   logic [1:0]   Op;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Busy;
   logic         Done;
   logic [W-1:0] Hi;
   logic [W-1:0] Lo;

   mult_div_unit #(.WIDTH(W)) dut (
      .Clock  (Clock),
      .ResetN (ResetN),
      .Start  (Start),
      .Op     (Op),
      .A      (A),
      .B      (B),
      .Busy   (Busy),
      .Done   (Done),
      .Hi     (Hi),
      .Lo     (Lo)
   );

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           start;
      string        name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   logic prev_done = 1'b0;

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   always @(posedge Clock) cyc <= cyc + 1;

   // Monitor: one comparison group per Done pulse
   always @(negedge Clock) begin
      exp_t e;
      int   lat;
      if (ResetN && Done) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: got Done with Hi=%h Lo=%h, required no Done", Hi, Lo);
         end else begin
            e   = sb.pop_front();
            lat = cyc - e.start;
            $display("txn %s: Hi=%h Lo=%h latency=%0d", e.name, Hi, Lo, lat);
            if (Hi !== e.hi) begin
               errors++;
               $display("FAIL %s_hi: got %h, required %h", e.name, Hi, e.hi);
            end
            checks++;
            if (Lo !== e.lo) begin
               errors++;
               $display("FAIL %s_lo: got %h, required %h", e.name, Lo, e.lo);
            end
            checks++;
            if (lat != W + 1) begin
               errors++;
               $display("FAIL %s_latency: got %0d, required %0d", e.name, lat, W + 1);
            end
         end
         checks++;
         if (prev_done) begin
            errors++;
            $display("FAIL done_pulse_width: got Done high two cycles, required one");
         end
      end
      prev_done = Done;
   end

   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                         input bit expect_result, input string name);
      exp_t e;
      @(negedge Clock);
      Start = 1'b1;
      Op    = op;
      A     = a;
      B     = b;
      if (expect_result) begin
         e.hi    = exp_hi;
         e.lo    = exp_lo;
         e.start = cyc + 1;
         e.name  = name;
         sb.push_back(e);
      end
      @(negedge Clock);
      Start = 1'b0;
      A     = $urandom;
      B     = $urandom;
      Op    = 2'($urandom_range(0, 3));
      checks++;
      if (Busy !== 1'b1) begin
         errors++;
         $display("FAIL %s_busy_after_start: got %b, required 1", name, Busy);
      end
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (Done !== 1'b1 && n < 100) begin
         @(negedge Clock);
         n++;
      end
      checks++;
      if (Done !== 1'b1) begin
         errors++;
         $display("FAIL %s_timeout: got no Done in %0d cycles, required Done", name, n);
      end else begin
         @(negedge Clock);
         checks++;
         if (Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_after_done: got Busy=%b Done=%b, required 0 0", name, Busy, Done);
         end
      end
   endtask

   task automatic check_zero(input string name);
      checks++;
      if (Busy !== 1'b0 || Done !== 1'b0 || Hi !== '0 || Lo !== '0) begin
         errors++;
         $display("FAIL %s: got Busy=%b Done=%b Hi=%h Lo=%h, required all 0", name, Busy, Done, Hi, Lo);
      end
   endtask

   initial begin
      ResetN = 1'b0;
      Start  = 1'b0;
      Op     = 2'b00;
      A      = '0;
      B      = '0;
      #12;
      check_zero("reset_state");
      @(negedge Clock);
      ResetN = 1'b1;

      run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1, "multu_max");
      wait_done("multu_max");
      run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1, "mult_neg3x7");
      wait_done("mult_neg3x7");
      run_op(OP_MULT, 32'd0, 32'hFFFFFFFB, 32'h0, 32'h0, 1, "mult_0xneg5");
      wait_done("mult_0xneg5");
      run_op(OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1, "mult_min_sq");
      wait_done("mult_min_sq");
      run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1, "div_neg7by2");
      wait_done("div_neg7by2");
      run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1, "div_7byneg2");
      wait_done("div_7byneg2");
      run_op(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1, "divu_100by7");
      wait_done("divu_100by7");
      run_op(OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1, "divu_by0");
      wait_done("divu_by0");
      run_op(OP_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1, "div_neg_by0");
      wait_done("div_neg_by0");
      run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1, "div_overflow");
      wait_done("div_overflow");

      // Second Start during RUN must be ignored
      run_op(OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1, "multu_ignore");
      repeat (9) @(negedge Clock);
      Start = 1'b1;
      Op    = OP_DIVU;
      A     = 32'hFFFFFFFF;
      B     = 32'hFFFFFFFF;
      @(negedge Clock);
      Start = 1'b0;
      wait_done("multu_ignore");
      repeat (40) @(negedge Clock);

      // Asynchronous reset in the middle of RUN
      run_op(OP_MULTU, 32'd3, 32'd5, '0, '0, 0, "multu_aborted");
      repeat (14) @(negedge Clock);
      ResetN = 1'b0;
      #1;
      check_zero("reset_mid_run");
      @(negedge Clock);
      ResetN = 1'b1;
      run_op(OP_DIVU, 32'd1000, 32'd33, 32'd10, 32'd30, 1, "divu_after_reset");
      wait_done("divu_after_reset");

      repeat (5) @(negedge Clock);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish by 200000, required finish");
      $fatal(1, "timeout");
   end

endmodule
